// File: rtl/cmul_arbiter.sv
// Round-robin arbiter sharing one pipelined complex multiplier among NUM_REQ requesters.
// Carries the requester id alongside the product and flags result/tag misalignment.
module cmul_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int WIDTH   = 17,
   parameter int MUL_LAT = 1
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_enable,
   input  logic [NUM_REQ-1:0]         i_req_valid,
   input  logic [NUM_REQ*WIDTH*2-1:0] i_req_a,
   input  logic [NUM_REQ*WIDTH*2-1:0] i_req_b,
   output logic [NUM_REQ-1:0]         o_req_ready,
   output logic                       o_mul_valid,
   output logic [WIDTH*2-1:0]         o_mul_a,
   output logic [WIDTH*2-1:0]         o_mul_b,
   input  logic                       i_mul_valid,
   input  logic [WIDTH*4+1:0]         i_mul_data,
   output logic                       o_rsp_valid,
   output logic [ID_W-1:0]            o_rsp_id,
   output logic [WIDTH*4+1:0]         o_rsp_data,
   output logic                       o_idle,
   output logic                       o_err
);

   localparam int OP_W    = 2 * WIDTH;
   localparam int CNT_MAX = MUL_LAT + 2;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   logic [ID_W-1:0]  ptr;
   logic [ID_W-1:0]  grant_id;
   logic [ID_W-1:0]  issue_id;
   logic             handshake;
   logic             tag_vld [MUL_LAT];
   logic [ID_W-1:0]  tag_id  [MUL_LAT];
   logic [CNT_W-1:0] count;
   int               idx;
   logic             found;

   // First valid requester at or after ptr, wrapping modulo NUM_REQ.
   always_comb begin
      o_req_ready = '0;
      grant_id    = '0;
      found       = 1'b0;
      idx         = 0;
      if (i_rst_n && i_enable) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && i_req_valid[idx]) begin
               found            = 1'b1;
               o_req_ready[idx] = 1'b1;
               grant_id         = ID_W'(idx);
            end
         end
      end
   end

   assign handshake = |(i_req_valid & o_req_ready);
   assign o_idle    = (count == '0);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         ptr         <= '0;
         issue_id    <= '0;
         o_mul_valid <= 1'b0;
         o_mul_a     <= '0;
         o_mul_b     <= '0;
         o_rsp_valid <= 1'b0;
         o_rsp_id    <= '0;
         o_rsp_data  <= '0;
         o_err       <= 1'b0;
         count       <= '0;
         for (int s = 0; s < MUL_LAT; s++) begin
            tag_vld[s] <= 1'b0;
            tag_id[s]  <= '0;
         end
      end else begin
         o_mul_valid <= handshake;
         if (handshake) begin
            o_mul_a  <= i_req_a[grant_id*OP_W +: OP_W];
            o_mul_b  <= i_req_b[grant_id*OP_W +: OP_W];
            issue_id <= grant_id;
            if (grant_id == ID_W'(NUM_REQ - 1))
               ptr <= '0;
            else
               ptr <= grant_id + ID_W'(1);
         end

         // Tag line starts at the issue register so its tail lines up with i_mul_valid.
         tag_vld[0] <= o_mul_valid;
         tag_id[0]  <= issue_id;
         for (int s = 1; s < MUL_LAT; s++) begin
            tag_vld[s] <= tag_vld[s-1];
            tag_id[s]  <= tag_id[s-1];
         end

         o_rsp_valid <= i_mul_valid;
         if (i_mul_valid) begin
            o_rsp_id   <= tag_id[MUL_LAT-1];
            o_rsp_data <= i_mul_data;
         end
         if (i_mul_valid != tag_vld[MUL_LAT-1])
            o_err <= 1'b1;

         // Saturating so a spurious response cannot wrap the count below zero.
         case ({handshake, o_rsp_valid})
            2'b10: if (count != CNT_W'(CNT_MAX)) count <= count + CNT_W'(1);
            2'b01: if (count != '0) count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_cmul_arbiter.sv
// Directed bench for cmul_arbiter: per-cycle vector table plus hand-written error and reset sequences.
// A one-stage complex multiplier model closes the loop between o_mul_* and i_mul_*.
module tb_cmul_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int WIDTH   = 17;
   localparam int MUL_LAT = 1;

   logic                       clk;
   logic                       rst_n;
   logic                       enable;
   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ*WIDTH*2-1:0] req_a;
   logic [NUM_REQ*WIDTH*2-1:0] req_b;
   logic [NUM_REQ-1:0]         req_ready;
   logic                       mul_valid_out;
   logic [WIDTH*2-1:0]         mul_a;
   logic [WIDTH*2-1:0]         mul_b;
   logic                       mul_valid_in;
   logic [WIDTH*4+1:0]         mul_data;
   logic                       rsp_valid;
   logic [ID_W-1:0]            rsp_id;
   logic [WIDTH*4+1:0]         rsp_data;
   logic                       idle;
   logic                       err;

   logic                       mul_v_q;
   logic [WIDTH*4+1:0]         mul_d_q;
   logic                       suppress;
   logic                       inject;

   int vec_count;
   int miscompares;

   typedef struct {
      logic [3:0] valid;
      logic       en;
      logic [3:0] ready;
      logic       mv;
      logic       rv;
      logic [1:0] id;
      logic       idl;
   } vec_t;

   vec_t vecs[$];

   cmul_arbiter #(
      .NUM_REQ(NUM_REQ), .ID_W(ID_W), .WIDTH(WIDTH), .MUL_LAT(MUL_LAT)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_enable   (enable),
      .i_req_valid(req_valid),
      .i_req_a    (req_a),
      .i_req_b    (req_b),
      .o_req_ready(req_ready),
      .o_mul_valid(mul_valid_out),
      .o_mul_a    (mul_a),
      .o_mul_b    (mul_b),
      .i_mul_valid(mul_valid_in),
      .i_mul_data (mul_data),
      .o_rsp_valid(rsp_valid),
      .o_rsp_id   (rsp_id),
      .o_rsp_data (rsp_data),
      .o_idle     (idle),
      .o_err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [69:0] cmul(input logic [33:0] a, input logic [33:0] b);
      logic signed [34:0] ar, ai, br, bi, re, im;
      ar = {{18{a[33]}}, a[33:17]};
      ai = {{18{a[16]}}, a[16:0]};
      br = {{18{b[33]}}, b[33:17]};
      bi = {{18{b[16]}}, b[16:0]};
      re = ar * br - ai * bi;
      im = ar * bi + ai * br;
      return {re, im};
   endfunction

   // Multiplier model, reset together with the arbiter.
   always @(posedge clk) begin
      if (!rst_n) begin
         mul_v_q <= 1'b0;
         mul_d_q <= '0;
      end else begin
         mul_v_q <= mul_valid_out;
         mul_d_q <= cmul(mul_a, mul_b);
      end
   end

   assign mul_valid_in = (mul_v_q & ~suppress) | inject;
   assign mul_data     = mul_d_q;

   task automatic applyStimulus(input logic [3:0] valid, input logic en);
      @(negedge clk);
      req_valid = valid;
      enable    = en;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [69:0] act, input logic [69:0] exp);
      vec_count++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic pulseReset(input int n);
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = '0;
      repeat (n) @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, " ready"},     70'(req_ready),     70'd0);
      checkOutput({tag, " mul_valid"}, 70'(mul_valid_out), 70'd0);
      checkOutput({tag, " mul_a"},     70'(mul_a),         70'd0);
      checkOutput({tag, " mul_b"},     70'(mul_b),         70'd0);
      checkOutput({tag, " rsp_valid"}, 70'(rsp_valid),     70'd0);
      checkOutput({tag, " rsp_id"},    70'(rsp_id),        70'd0);
      checkOutput({tag, " rsp_data"},  rsp_data,           70'd0);
      checkOutput({tag, " err"},       70'(err),           70'd0);
      checkOutput({tag, " idle"},      70'(idle),          70'd1);
   endtask

   initial begin
      vec_count   = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      enable      = 1'b1;
      req_valid   = '0;
      suppress    = 1'b0;
      inject      = 1'b0;
      req_a       = '0;
      req_b       = '0;

      // Fairness, pointer rotation and drain as one continuous per-cycle table.
      vecs.push_back(vec_t'{4'b1111, 1'b1, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b1});
      vecs.push_back(vec_t'{4'b1111, 1'b1, 4'b0010, 1'b1, 1'b0, 2'd0, 1'b0});
      vecs.push_back(vec_t'{4'b1111, 1'b1, 4'b0100, 1'b1, 1'b0, 2'd0, 1'b0});
      vecs.push_back(vec_t'{4'b1111, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd0, 1'b0});
      vecs.push_back(vec_t'{4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd1, 1'b0});
      vecs.push_back(vec_t'{4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd2, 1'b0});
      vecs.push_back(vec_t'{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b0});
      vecs.push_back(vec_t'{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0});
      vecs.push_back(vec_t'{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b0});
      vecs.push_back(vec_t'{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b1});
      vecs.push_back(vec_t'{4'b0010, 1'b1, 4'b0010, 1'b0, 1'b0, 2'd1, 1'b1});
      vecs.push_back(vec_t'{4'b1001, 1'b1, 4'b1000, 1'b1, 1'b0, 2'd1, 1'b0});
      vecs.push_back(vec_t'{4'b1001, 1'b1, 4'b0001, 1'b1, 1'b0, 2'd1, 1'b0});
      vecs.push_back(vec_t'{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b0});
      vecs.push_back(vec_t'{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd3, 1'b0});
      vecs.push_back(vec_t'{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0});
      vecs.push_back(vec_t'{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1});
      vecs.push_back(vec_t'{4'b1111, 1'b1, 4'b0010, 1'b0, 1'b0, 2'd0, 1'b1});
      vecs.push_back(vec_t'{4'b1111, 1'b1, 4'b0100, 1'b1, 1'b0, 2'd0, 1'b0});
      vecs.push_back(vec_t'{4'b1111, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0});
      vecs.push_back(vec_t'{4'b1111, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b0});
      vecs.push_back(vec_t'{4'b1111, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b0});
      vecs.push_back(vec_t'{4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b1});
      vecs.push_back(vec_t'{4'b1111, 1'b1, 4'b1000, 1'b0, 1'b0, 2'd2, 1'b1});
      vecs.push_back(vec_t'{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b0});
      vecs.push_back(vec_t'{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0});
      vecs.push_back(vec_t'{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd3, 1'b0});
      vecs.push_back(vec_t'{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd3, 1'b1});

      pulseReset(2);
      checkResetState("reset");

      // Single request from requester 2: (16384,0) x (16384,0).
      req_a[2*34 +: 34] = {17'd16384, 17'd0};
      req_b[2*34 +: 34] = {17'd16384, 17'd0};
      req_a[0 +: 34]    = {17'd100, 17'd3};
      req_b[0 +: 34]    = {17'd7, 17'd1};
      applyStimulus(4'b0100, 1'b1);
      checkOutput("single ready", 70'(req_ready), 70'(4'b0100));
      applyStimulus(4'b0000, 1'b1);
      checkOutput("single mul_valid", 70'(mul_valid_out), 70'd1);
      checkOutput("single mul_a", 70'(mul_a), 70'({17'd16384, 17'd0}));
      checkOutput("single mul_b", 70'(mul_b), 70'({17'd16384, 17'd0}));
      applyStimulus(4'b0000, 1'b1);
      checkOutput("single rsp early", 70'(rsp_valid), 70'd0);
      checkOutput("single busy", 70'(idle), 70'd0);
      applyStimulus(4'b0000, 1'b1);
      checkOutput("single rsp_valid", 70'(rsp_valid), 70'd1);
      checkOutput("single rsp_id", 70'(rsp_id), 70'd2);
      checkOutput("single rsp_data", rsp_data, {35'd268435456, 35'd0});
      applyStimulus(4'b0000, 1'b1);
      checkOutput("single rsp end", 70'(rsp_valid), 70'd0);
      checkOutput("single idle", 70'(idle), 70'd1);

      pulseReset(1);
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].valid, vecs[i].en);
         checkOutput($sformatf("row%0d ready", i),     70'(req_ready),     70'(vecs[i].ready));
         checkOutput($sformatf("row%0d mul_valid", i), 70'(mul_valid_out), 70'(vecs[i].mv));
         checkOutput($sformatf("row%0d rsp_valid", i), 70'(rsp_valid),     70'(vecs[i].rv));
         checkOutput($sformatf("row%0d rsp_id", i),    70'(rsp_id),        70'(vecs[i].id));
         checkOutput($sformatf("row%0d idle", i),      70'(idle),          70'(vecs[i].idl));
      end

      // Spurious multiplier result with nothing in flight.
      @(negedge clk);
      inject = 1'b1;
      #1;
      checkOutput("spur err before", 70'(err), 70'd0);
      @(negedge clk);
      inject = 1'b0;
      #1;
      checkOutput("spur err", 70'(err), 70'd1);
      checkOutput("spur rsp_valid", 70'(rsp_valid), 70'd1);
      repeat (3) applyStimulus(4'b0000, 1'b1);
      checkOutput("spur err sticky", 70'(err), 70'd1);
      checkOutput("spur rsp end", 70'(rsp_valid), 70'd0);
      pulseReset(1);
      checkOutput("err cleared", 70'(err), 70'd0);

      // Expected result suppressed.
      applyStimulus(4'b0001, 1'b1);
      checkOutput("supp ready", 70'(req_ready), 70'(4'b0001));
      applyStimulus(4'b0000, 1'b1);
      checkOutput("supp mul_valid", 70'(mul_valid_out), 70'd1);
      suppress = 1'b1;
      applyStimulus(4'b0000, 1'b1);
      checkOutput("supp err before", 70'(err), 70'd0);
      applyStimulus(4'b0000, 1'b1);
      suppress = 1'b0;
      checkOutput("supp err", 70'(err), 70'd1);
      checkOutput("supp no rsp", 70'(rsp_valid), 70'd0);
      checkOutput("supp not idle", 70'(idle), 70'd0);

      // Reset with three products in flight.
      pulseReset(1);
      applyStimulus(4'b1111, 1'b1);
      checkOutput("mid ready0", 70'(req_ready), 70'(4'b0001));
      applyStimulus(4'b1111, 1'b1);
      checkOutput("mid ready1", 70'(req_ready), 70'(4'b0010));
      applyStimulus(4'b1111, 1'b1);
      checkOutput("mid ready2", 70'(req_ready), 70'(4'b0100));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("mid ready in reset", 70'(req_ready), 70'd0);
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = '0;
      #1;
      checkResetState("mid");
      applyStimulus(4'b1111, 1'b1);
      checkOutput("mid restart ready", 70'(req_ready), 70'(4'b0001));
      applyStimulus(4'b0000, 1'b1);
      applyStimulus(4'b0000, 1'b1);
      applyStimulus(4'b0000, 1'b1);
      checkOutput("mid restart rsp", 70'(rsp_valid), 70'd1);
      checkOutput("mid restart id", 70'(rsp_id), 70'd0);
      checkOutput("mid no err", 70'(err), 70'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule

// File: doc/cmul_arbiter.md
# cmul_arbiter

Round-robin arbiter and tag tracker that shares one pipelined complex multiplier among `NUM_REQ` requesters in the sphere-decoder datapath. Typical requesters are the QR, partial-Euclidean-distance and interference-cancellation units. Each cycle it grants at most one pending request and registers the selected operand pair into the multiplier. It carries the requester ID through a delay line matched to `MUL_LAT` and returns each product to its requester with that ID. It also supports drain/idle control and flags response mismatches.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters (2..8).
- `ID_W`, default 2: requester ID width; must satisfy `ID_W = clog2(NUM_REQ)`.
- `WIDTH`, default 17: operand component width (Q2.15, signed).
- `MUL_LAT`, default 1: cycles from the multiplier's input valid to its output valid (≥1).

Ports:
- `i_clk`, in, 1: clock. One clock; reset is synchronous and active-low.
- `i_rst_n`, in, 1: synchronous active-low reset, sampled on `posedge i_clk`.
- `i_enable`, in, 1: grants are allowed only when high.
- `i_req_valid`, in, `NUM_REQ`: per-requester request valid.
- `i_req_a`, in, `NUM_REQ*WIDTH*2`: operand A for each requester; slot k holds `{real, imag}` at `[k*2W +: 2W]`.
- `i_req_b`, in, `NUM_REQ*WIDTH*2`: operand B, same packing as `i_req_a`.
- `o_req_ready`, out, `NUM_REQ`: one-hot grant; handshake completes when `valid & ready`.
- `o_mul_valid`, out, 1: issue strobe to the multiplier.
- `o_mul_a`, out, `WIDTH*2`: multiplier operand A.
- `o_mul_b`, out, `WIDTH*2`: multiplier operand B.
- `i_mul_valid`, in, 1: multiplier result valid.
- `i_mul_data`, in, `WIDTH*4+2`: multiplier result `{real, imag}`, each component `2W+1` bits.
- `o_rsp_valid`, out, 1: response strobe (single cycle, no backpressure).
- `o_rsp_id`, out, `ID_W`: ID of the requester that owns the response.
- `o_rsp_data`, out, `WIDTH*4+2`: registered copy of `i_mul_data`.
- `o_idle`, out, 1: high when nothing is in flight.
- `o_err`, out, 1: sticky error flag.

## Operation
- **Round-robin pointer.**
  - `ptr` has width `ID_W` and resets to 0.
  - The winner is the first index k, searched `ptr, ptr+1, …` modulo `NUM_REQ`, with `i_req_valid[k]` high.
  - After a grant to k, `ptr` becomes `(k+1) mod NUM_REQ`. It does not change in cycles with no grant.
- **Grant.**
  - `o_req_ready` is combinational from `i_req_valid`, `ptr` and `i_enable`.
  - It is all-zero when `i_enable` is 0, when no request is valid, or when reset is asserted.
  - At most one bit is set.
- **Issue register.**
  - On a handshake to k, the next edge loads `o_mul_a` and `o_mul_b` from slot k and sets `o_mul_valid` to 1.
  - Without a handshake, `o_mul_valid` goes to 0 and the operand registers hold their values.
- **Tag line.**
  - A `{vld, id}` shift register, `MUL_LAT` deep, is loaded on each issue. It advances every cycle.
  - Its tail is aligned with `i_mul_valid`.
- **Response.**
  - On the edge after `i_mul_valid`, `o_rsp_valid` goes to 1, `o_rsp_id` takes the tail id, and `o_rsp_data` takes `i_mul_data`.
  - Otherwise `o_rsp_valid` is 0 and `o_rsp_id`/`o_rsp_data` hold their values.
- **Error.**
  - `o_err` is set when `i_mul_valid` differs from the tail `vld`, in either direction.
  - It is sticky until reset.
  - On a spurious result, the arbiter still emits `o_rsp_valid`, using the tail id.
- **In-flight counter.**
  - The counter spans 0..`MUL_LAT+2` and counts issued-but-not-responded products.
  - It increments on a handshake and decrements on an `o_rsp_valid` cycle; both in one cycle leave it unchanged.
  - `o_idle = (count == 0)`.
- **Drain.** Dropping `i_enable` stops new grants. In-flight products still complete and `o_idle` rises after the last response.
- **Arithmetic.** The arbiter performs none. Data passes through bit-exact, with no sign extension or truncation.

## Timing
- **Reset values.**
  - 0: `o_req_ready`, `o_mul_valid`, `o_mul_a`, `o_mul_b`, `o_rsp_valid`, `o_rsp_id`, `o_rsp_data`, `o_err`, `ptr`, tag line, counter.
  - 1: `o_idle`.
- **Latency.**
  - Handshake at edge t gives `o_mul_valid` high during cycle t+1.
  - The multiplier result arrives at t+1+`MUL_LAT`.
  - `o_rsp_valid` is high during cycle t+2+`MUL_LAT`.
- **Throughput.** One grant per cycle; back-to-back grants to different or the same requesters are allowed.
- **Single requester.** A requester asserting continuously alone is granted every cycle.
- **Reset mid-operation.** Asserting `i_rst_n=0` with products in flight clears the tag line and counter. Later multiplier results are then spurious and set `o_err`; the integration must reset the multiplier together with the arbiter.
- **Enable and request changes.** `i_enable` falling in a cycle with a pending request yields no grant that cycle. A request withdrawn before handshake is never issued.

## Test plan
- **Single request, full latency.** Bench multiplier model with `MUL_LAT=1`. Requester 2 sends a=(16384,0), b=(16384,0), valid for one cycle.
  - `o_req_ready`=4'b0100 in that cycle.
  - `o_mul_valid` 1 cycle later.
  - `o_rsp_valid` 3 cycles after the handshake, with `o_rsp_id`=2 and real=268435456, imag=0.
  - `o_idle` returns to 1.
- **Fairness.** All 4 valid continuously.
  - Grants go 0,1,2,3,0,1,… on consecutive cycles.
  - Response ids come out in the same order, one per cycle after a 3-cycle lag.
- **Pointer rotation.** Grant requester 1 alone, then raise requesters 0 and 3 together → 3 is granted before 0.
- **Drain.** Drop `i_enable` while 2 products are in flight, with requesters still valid.
  - No new grants.
  - Exactly 2 responses are delivered.
  - `o_idle`=1 after the second response.
  - Raising `i_enable` resumes granting from the saved `ptr`.
- **Error injection.**
  - Force `i_mul_valid` high with nothing in flight → `o_err`=1 on the next edge and it stays 1.
  - Suppress an expected `i_mul_valid` → `o_err` is set.
- **Reset mid-flight.** Reset for 1 cycle with 3 products in flight → all outputs return to their reset values and the counter is 0. New requests are granted starting from requester 0.
